// File: rtl/axis_coeff_reduce.sv
// AXI-stream coefficient reducer: folds raw words into [0,Q),
// regenerates frame boundaries, flags framing errors; OR+skid output.
//
// Ports:
//   clk, s_rst          clock, synchronous active-high reset
//   s_data/s_vld/s_last input stream, s_rdy registered ready
//   m_data/m_vld/m_last output stream, m_rdy downstream ready
//   err_early_last      pulse: s_last before the final beat
//   err_missing_last    pulse: final beat without s_last
//   frame_cnt           frames accepted (wrapping)
//   err_cnt             framing errors (saturating)
module axis_coeff_reduce #(
  parameter int N = 16,
  parameter int DATAW = 64,
  parameter int COEFFW = 32,
  parameter logic [COEFFW-1:0] Q = 32'hFFFF_FFFB,
  parameter int CNTW = 32
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic [DATAW-1:0]  s_data,
  input  logic              s_vld,
  input  logic              s_last,
  output logic              s_rdy,
  output logic [COEFFW-1:0] m_data,
  output logic              m_vld,
  output logic              m_last,
  input  logic              m_rdy,
  output logic              err_early_last,
  output logic              err_missing_last,
  output logic [CNTW-1:0]   frame_cnt,
  output logic [15:0]       err_cnt
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LASTB = CW'(N - 1);

  logic [CW-1:0]     r_cnt;
  logic              r_rdy;
  logic              r_or_vld;
  logic              r_or_last;
  logic [COEFFW-1:0] r_or_data;
  logic              r_sk_vld;
  logic              r_sk_last;
  logic [COEFFW-1:0] r_sk_data;
  logic              r_err_early;
  logic              r_err_miss;
  logic [CNTW-1:0]   r_frame_cnt;
  logic [15:0]       r_err_cnt;

  logic [COEFFW-1:0] w_x;
  logic [COEFFW-1:0] w_y;
  logic              w_acc;
  logic              w_drain;
  logic              w_end;
  logic              w_term;
  logic              w_early;
  logic              w_miss;
  logic              w_sk_nxt;

  // Q > 2^(COEFFW-1), so one subtraction always lands in [0,Q).
  assign w_x = s_data[COEFFW-1:0];
  assign w_y = (w_x >= Q) ? w_x - Q : w_x;

  assign w_acc   = s_vld & r_rdy;
  assign w_drain = r_or_vld & m_rdy;
  assign w_end   = (r_cnt == LASTB);
  assign w_term  = s_last | w_end;
  assign w_early = w_acc & s_last & ~w_end;
  assign w_miss  = w_acc & ~s_last & w_end;

  // Skid holds a beat only when OR is stuck; it empties on any drain.
  assign w_sk_nxt = r_sk_vld ? ~w_drain
                             : (w_acc & r_or_vld & ~w_drain);

  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_cnt       <= '0;
      r_rdy       <= 1'b0;
      r_or_vld    <= 1'b0;
      r_or_last   <= 1'b0;
      r_or_data   <= '0;
      r_sk_vld    <= 1'b0;
      r_sk_last   <= 1'b0;
      r_sk_data   <= '0;
      r_err_early <= 1'b0;
      r_err_miss  <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_early <= w_early;
      r_err_miss  <= w_miss;
      if ((w_early | w_miss) && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;

      if (w_acc) begin
        r_cnt <= w_term ? '0 : r_cnt + CW'(1);
        if (w_term)
          r_frame_cnt <= r_frame_cnt + CNTW'(1);
      end

      r_sk_vld <= w_sk_nxt;
      r_rdy    <= ~w_sk_nxt;

      if (r_sk_vld) begin
        if (w_drain) begin
          r_or_data <= r_sk_data;
          r_or_last <= r_sk_last;
        end
      end else if (w_acc) begin
        if (!r_or_vld || w_drain) begin
          r_or_vld  <= 1'b1;
          r_or_data <= w_y;
          r_or_last <= w_term;
        end else begin
          r_sk_data <= w_y;
          r_sk_last <= w_term;
        end
      end else if (w_drain) begin
        r_or_vld <= 1'b0;
      end
    end
  end

  assign s_rdy            = r_rdy;
  assign m_data           = r_or_data;
  assign m_vld            = r_or_vld;
  assign m_last           = r_or_last;
  assign err_early_last   = r_err_early;
  assign err_missing_last = r_err_miss;
  assign frame_cnt        = r_frame_cnt;
  assign err_cnt          = r_err_cnt;

endmodule
